// File: rtl/sync_token_branch_pkg.sv
// Shared packet definitions for the token branch and its merge-side counterpart.
// Field widths, FSM state encoding, packet struct and the local-route test.
package sync_token_branch_pkg;

    localparam int NODE_W = 16;
    localparam int GEN_W  = 12;
    localparam int OPR_W  = 32;
    localparam int WEN_W  = 2;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FC    = 2'd1,
        SW0   = 2'd2,
        SW1   = 2'd3
    } state_t;

    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic [OPR_W-1:0]  opr0;
        logic [OPR_W-1:0]  opr1;
        logic [WEN_W-1:0]  mem_wen;
    } pkt_t;

    // The upper byte of the node field names the destination node.
    function automatic logic is_local(input logic [NODE_W-1:0] node, input logic [7:0] id);
        return node[15:8] == id;
    endfunction

endpackage

// File: rtl/sync_token_branch_sat_counter16.sv
// Purpose: 16-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after the enabling edge.
// Backpressure: none; counts every cycle en is high.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'h0000;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'h0001;
        end
    end

endmodule

// File: rtl/sync_token_branch.sv
// Purpose: steer each packet to the local fire path (FC) or serialize it as two switch flits (SW).
// Latency: 1 cycle from input transfer to output valid; FC 1 pkt/cycle, SW 1 pkt/2 cycles.
// Backpressure: single holding register; ready_o only when empty or the held packet leaves this edge.
module sync_token_branch
    import sync_token_branch_pkg::*;
#(
    parameter logic [7:0] LOCAL_ID = 8'h00
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [NODE_W-1:0] node_i_stb,
    input  logic [GEN_W-1:0]  gen_i_stb,
    input  logic [OPR_W-1:0]  opr0_i_stb,
    input  logic [OPR_W-1:0]  opr1_i_stb,
    input  logic [WEN_W-1:0]  mem_wen_i_stb,
    input  logic              valid_i_stb,
    output logic              ready_o_stb,

    output logic [NODE_W-1:0] node_fc_o_stb,
    output logic [GEN_W-1:0]  gen_fc_o_stb,
    output logic [OPR_W-1:0]  opr0_fc_o_stb,
    output logic [OPR_W-1:0]  opr1_fc_o_stb,
    output logic [WEN_W-1:0]  mem_wen_fc_o_stb,
    output logic              valid_fc_o_stb,
    input  logic              ready_fc_i_stb,

    output logic [NODE_W-1:0] node_sw_o_stb,
    output logic [GEN_W-1:0]  gen_sw_o_stb,
    output logic [WEN_W-1:0]  mem_wen_sw_o_stb,
    output logic [OPR_W-1:0]  opr_sw_o_stb,
    output logic              last_sw_o_stb,
    output logic              valid_sw_o_stb,
    input  logic              ready_sw_i_stb,

    output logic [CNT_W-1:0]  cnt_fc_o_stb,
    output logic [CNT_W-1:0]  cnt_sw_o_stb
);

    state_t state_q, state_d, route_st;
    pkt_t   pkt_q;
    logic   in_xfer;
    logic   fc_done;
    logic   sw_done;

    always_comb begin
        route_st = is_local(node_i_stb, LOCAL_ID) ? FC : SW0;
        fc_done  = (state_q == FC)  && ready_fc_i_stb;
        sw_done  = (state_q == SW1) && ready_sw_i_stb;
        // No path from valid_i here: ready depends only on state and downstream ready.
        ready_o_stb = (state_q == EMPTY) || fc_done || sw_done;
        in_xfer     = valid_i_stb && ready_o_stb;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (in_xfer) state_d = route_st;
            FC:    if (ready_fc_i_stb) state_d = in_xfer ? route_st : EMPTY;
            SW0:   if (ready_sw_i_stb) state_d = SW1;
            SW1:   if (ready_sw_i_stb) state_d = in_xfer ? route_st : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                pkt_q <= '{node: node_i_stb, gen: gen_i_stb, opr0: opr0_i_stb,
                           opr1: opr1_i_stb, mem_wen: mem_wen_i_stb};
            end
        end
    end

    // Outputs of the path not currently holding the packet are forced to zero.
    always_comb begin
        node_fc_o_stb    = '0;
        gen_fc_o_stb     = '0;
        opr0_fc_o_stb    = '0;
        opr1_fc_o_stb    = '0;
        mem_wen_fc_o_stb = '0;
        valid_fc_o_stb   = 1'b0;
        node_sw_o_stb    = '0;
        gen_sw_o_stb     = '0;
        mem_wen_sw_o_stb = '0;
        opr_sw_o_stb     = '0;
        last_sw_o_stb    = 1'b0;
        valid_sw_o_stb   = 1'b0;
        unique case (state_q)
            FC: begin
                node_fc_o_stb    = pkt_q.node;
                gen_fc_o_stb     = pkt_q.gen;
                opr0_fc_o_stb    = pkt_q.opr0;
                opr1_fc_o_stb    = pkt_q.opr1;
                mem_wen_fc_o_stb = pkt_q.mem_wen;
                valid_fc_o_stb   = 1'b1;
            end
            SW0, SW1: begin
                node_sw_o_stb    = pkt_q.node;
                gen_sw_o_stb     = pkt_q.gen;
                mem_wen_sw_o_stb = pkt_q.mem_wen;
                opr_sw_o_stb     = (state_q == SW1) ? pkt_q.opr1 : pkt_q.opr0;
                last_sw_o_stb    = (state_q == SW1);
                valid_sw_o_stb   = 1'b1;
            end
            default: ;
        endcase
    end

    sat_counter16 u_cnt_fc (
        .clk (clk),
        .rst (rst),
        .en  (fc_done),
        .cnt (cnt_fc_o_stb)
    );

    sat_counter16 u_cnt_sw (
        .clk (clk),
        .rst (rst),
        .en  (sw_done),
        .cnt (cnt_sw_o_stb)
    );

endmodule

// File: tb/tb_sync_token_branch.sv
// Directed scenarios plus a randomized run against a packet-queue reference model.
module tb_sync_token_branch;
    import sync_token_branch_pkg::*;

    localparam logic [7:0] LID = 8'h05;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] node_i;
    logic [11:0] gen_i;
    logic [31:0] opr0_i, opr1_i;
    logic [1:0]  wen_i;
    logic        valid_i, ready_o;
    logic [15:0] node_fc;
    logic [11:0] gen_fc;
    logic [31:0] opr0_fc, opr1_fc;
    logic [1:0]  wen_fc;
    logic        valid_fc, ready_fc;
    logic [15:0] node_sw;
    logic [11:0] gen_sw;
    logic [1:0]  wen_sw;
    logic [31:0] opr_sw;
    logic        last_sw, valid_sw, ready_sw;
    logic [15:0] cnt_fc, cnt_sw;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_token_branch #(.LOCAL_ID(LID)) dut (
        .clk(clk), .rst(rst),
        .node_i_stb(node_i), .gen_i_stb(gen_i), .opr0_i_stb(opr0_i), .opr1_i_stb(opr1_i),
        .mem_wen_i_stb(wen_i), .valid_i_stb(valid_i), .ready_o_stb(ready_o),
        .node_fc_o_stb(node_fc), .gen_fc_o_stb(gen_fc), .opr0_fc_o_stb(opr0_fc),
        .opr1_fc_o_stb(opr1_fc), .mem_wen_fc_o_stb(wen_fc), .valid_fc_o_stb(valid_fc),
        .ready_fc_i_stb(ready_fc),
        .node_sw_o_stb(node_sw), .gen_sw_o_stb(gen_sw), .mem_wen_sw_o_stb(wen_sw),
        .opr_sw_o_stb(opr_sw), .last_sw_o_stb(last_sw), .valid_sw_o_stb(valid_sw),
        .ready_sw_i_stb(ready_sw),
        .cnt_fc_o_stb(cnt_fc), .cnt_sw_o_stb(cnt_sw)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] n, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] g, input logic [1:0] w);
        node_i = n; opr0_i = a; opr1_i = b; gen_i = g; wen_i = w; valid_i = 1'b1;
    endtask

    task automatic test_reset();
        ready_fc = 1'b1; ready_sw = 1'b1;
        drive(16'h0512, 32'hAAAA_0001, 32'hBBBB_0001, 12'h123, 2'b01);
        rst = 1'b1;
        step(); step();
        #1;
        total++;
        if ({valid_fc, valid_sw, ready_o, cnt_fc, cnt_sw} !== {1'b0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
            bad++; $display("FAIL reset_ctrl: got vfc=%b vsw=%b rdy=%b cfc=%h csw=%h, want 0 0 1 0 0",
                            valid_fc, valid_sw, ready_o, cnt_fc, cnt_sw);
        end
        total++;
        if ({node_fc, gen_fc, opr0_fc, opr1_fc, wen_fc, node_sw, gen_sw, wen_sw, opr_sw, last_sw} !== '0) begin
            bad++; $display("FAIL reset_data: fc/sw payload not zero (node_fc=%h opr_sw=%h last=%b)",
                            node_fc, opr_sw, last_sw);
        end
        step();
        rst = 1'b0;
        step();
        valid_i = 1'b0;
        #1;
        total++;
        if (valid_fc !== 1'b1 || node_fc !== 16'h0512 || opr0_fc !== 32'hAAAA_0001) begin
            bad++; $display("FAIL reset_first_pkt: got vfc=%b node=%h opr0=%h, want 1 0512 aaaa0001",
                            valid_fc, node_fc, opr0_fc);
        end
    endtask

    task automatic test_fc();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        ready_fc = 1'b1;
        step();
        drive(16'h0512, a, b, 12'hABC, 2'b10);
        step();
        valid_i = 1'b0;
        #1;
        total++;
        if ({valid_fc, valid_sw, node_fc, gen_fc, opr0_fc, opr1_fc, wen_fc} !==
            {1'b1, 1'b0, 16'h0512, 12'hABC, a, b, 2'b10}) begin
            bad++; $display("FAIL fc_fields: got v=%b/%b node=%h gen=%h o0=%h o1=%h w=%b, want 1/0 0512 abc %h %h 10",
                            valid_fc, valid_sw, node_fc, gen_fc, opr0_fc, opr1_fc, wen_fc, a, b);
        end
        step();
        #1;
        total++;
        if (cnt_fc !== 16'd2 || cnt_sw !== 16'd0 || valid_fc !== 1'b0) begin
            bad++; $display("FAIL fc_count: got cfc=%0d csw=%0d vfc=%b, want 2 0 0", cnt_fc, cnt_sw, valid_fc);
        end
    endtask

    task automatic test_sw();
        ready_sw = 1'b1;
        drive(16'h0700, 32'h11, 32'h22, 12'h001, 2'b11);
        step();
        valid_i = 1'b0;
        #1;
        total++;
        if ({valid_sw, valid_fc, opr_sw, last_sw, ready_o, node_sw} !== {1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 16'h0700}) begin
            bad++; $display("FAIL sw_flit0: got v=%b vfc=%b opr=%h last=%b rdy=%b node=%h, want 1 0 11 0 0 0700",
                            valid_sw, valid_fc, opr_sw, last_sw, ready_o, node_sw);
        end
        step();
        #1;
        total++;
        if ({valid_sw, opr_sw, last_sw, ready_o} !== {1'b1, 32'h22, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sw_flit1: got v=%b opr=%h last=%b rdy=%b, want 1 22 1 1",
                            valid_sw, opr_sw, last_sw, ready_o);
        end
        step();
        #1;
        total++;
        if (valid_sw !== 1'b0 || cnt_sw !== 16'd1) begin
            bad++; $display("FAIL sw_count: got vsw=%b csw=%0d, want 0 1", valid_sw, cnt_sw);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = cnt_fc;
        ready_fc = 1'b1; ready_sw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(16'h0500 | 16'(k), 32'h100 + 32'(k), 32'h200 + 32'(k), 12'(k), 2'(k));
            #1;
            total++;
            if (ready_o !== 1'b1) begin
                bad++; $display("FAIL b2b_ready[%0d]: got %b, want 1", k, ready_o);
            end
            step();
            #1;
            total++;
            if (valid_fc !== 1'b1 || opr0_fc !== 32'h100 + 32'(k)) begin
                bad++; $display("FAIL b2b_fc[%0d]: got v=%b opr0=%h, want 1 %h", k, valid_fc, opr0_fc, 32'h100 + 32'(k));
            end
        end
        drive(16'h0900, 32'h33, 32'h44, 12'h0, 2'b00);
        step();
        valid_i = 1'b0;
        #1;
        total++;
        if (valid_sw !== 1'b1 || valid_fc !== 1'b0 || opr_sw !== 32'h33 || cnt_fc !== base + 16'd4) begin
            bad++; $display("FAIL fc_then_sw: got vsw=%b vfc=%b opr=%h cfc=%h, want 1 0 33 %h",
                            valid_sw, valid_fc, opr_sw, cnt_fc, base + 16'd4);
        end
        step(); step();
    endtask

    task automatic test_stall_reset();
        ready_sw = 1'b0;
        drive(16'h0A01, 32'hCAFE_0001, 32'hCAFE_0002, 12'h055, 2'b01);
        step();
        drive(16'h0502, 32'h1, 32'h2, 12'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({valid_sw, opr_sw, last_sw, ready_o} !== {1'b1, 32'hCAFE_0001, 1'b0, 1'b0}) begin
                bad++; $display("FAIL stall[%0d]: got v=%b opr=%h last=%b rdy=%b, want 1 cafe0001 0 0",
                                i, valid_sw, opr_sw, last_sw, ready_o);
            end
            step();
        end
        valid_i = 1'b0; ready_sw = 1'b1;
        step();
        ready_sw = 1'b0;
        #1;
        total++;
        if ({last_sw, opr_sw} !== {1'b1, 32'hCAFE_0002}) begin
            bad++; $display("FAIL stall_sw1: got last=%b opr=%h, want 1 cafe0002", last_sw, opr_sw);
        end
        rst = 1'b1;
        #1;
        total++;
        if (valid_sw !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pkt: got vsw=%b rdy=%b, want 0 1", valid_sw, ready_o);
        end
        step();
        rst = 1'b0; ready_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (valid_sw !== 1'b0 || valid_fc !== 1'b0) begin
                bad++; $display("FAIL no_flit_after_rst[%0d]: got vsw=%b vfc=%b, want 0 0", i, valid_sw, valid_fc);
            end
            step();
        end
        total++;
        if (cnt_sw !== 16'd0) begin
            bad++; $display("FAIL rst_cnt_sw: got %0d, want 0", cnt_sw);
        end
    endtask

    task automatic test_saturate();
        ready_fc = 1'b1;
        force dut.u_cnt_fc.cnt = 16'hFFFE;
        #1;
        release dut.u_cnt_fc.cnt;
        drive(16'h0501, 32'h1, 32'h1, 12'h1, 2'b01);
        step();
        drive(16'h0502, 32'h2, 32'h2, 12'h2, 2'b10);
        #1;
        total++;
        if (cnt_fc !== 16'hFFFE) begin
            bad++; $display("FAIL sat_preload: got %h, want fffe", cnt_fc);
        end
        step();
        drive(16'h0503, 32'h3, 32'h3, 12'h3, 2'b11);
        #1;
        total++;
        if (cnt_fc !== 16'hFFFF) begin
            bad++; $display("FAIL sat_first: got %h, want ffff", cnt_fc);
        end
        step();
        valid_i = 1'b0;
        step();
        #1;
        total++;
        if (cnt_fc !== 16'hFFFF || valid_fc !== 1'b0) begin
            bad++; $display("FAIL sat_hold: got cnt=%h vfc=%b, want ffff 0", cnt_fc, valid_fc);
        end
    endtask

    // Reference model: an ordered packet queue; a remote head packet leaves as two flits.
    task automatic test_random();
        pkt_t q[$];
        pkt_t p;
        bit   half;
        int   m_fc, m_sw, errs;
        bit   has, loc, e_vfc, e_vsw, e_rdy;
        rst = 1'b1; valid_i = 1'b0;
        step();
        rst = 1'b0;
        half = 1'b0; m_fc = 0; m_sw = 0; errs = 0;
        for (int c = 0; c < 2000; c++) begin
            p.node    = ($urandom_range(1, 0) == 1) ? {LID, 8'($urandom)} : {8'($urandom_range(255, 6)), 8'($urandom)};
            p.gen     = 12'($urandom);
            p.opr0    = $urandom;
            p.opr1    = $urandom;
            p.mem_wen = 2'($urandom);
            drive(p.node, p.opr0, p.opr1, p.gen, p.mem_wen);
            valid_i  = ($urandom_range(9, 0) < 6);
            ready_fc = ($urandom_range(9, 0) < 7);
            ready_sw = ($urandom_range(9, 0) < 7);
            #1;
            has   = (q.size() > 0);
            loc   = has && (q[0].node[15:8] == LID);
            e_vfc = has && loc;
            e_vsw = has && !loc;
            e_rdy = !has || (e_vfc && ready_fc) || (e_vsw && half && ready_sw);
            total++;
            if ({valid_fc, valid_sw, ready_o} !== {e_vfc, e_vsw, e_rdy}) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_ctrl@%0d: got vfc/vsw/rdy=%b%b%b, want %b%b%b",
                                        c, valid_fc, valid_sw, ready_o, e_vfc, e_vsw, e_rdy);
            end
            total++;
            if (cnt_fc !== 16'(m_fc) || cnt_sw !== 16'(m_sw)) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rnd_cnt@%0d: got fc=%0d sw=%0d, want %0d %0d", c, cnt_fc, cnt_sw, m_fc, m_sw);
            end
            if (e_vfc) begin
                total++;
                if ({node_fc, gen_fc, opr0_fc, opr1_fc, wen_fc} !== q[0]) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rnd_fc@%0d: got %h, want %h", c,
                                            {node_fc, gen_fc, opr0_fc, opr1_fc, wen_fc}, q[0]);
                end
            end
            if (e_vsw) begin
                total++;
                if ({node_sw, gen_sw, wen_sw, opr_sw, last_sw} !==
                    {q[0].node, q[0].gen, q[0].mem_wen, half ? q[0].opr1 : q[0].opr0, half}) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rnd_sw@%0d: got node=%h opr=%h last=%b, want %h %h %b", c,
                                            node_sw, opr_sw, last_sw, q[0].node, half ? q[0].opr1 : q[0].opr0, half);
                end
            end
            if (e_vfc && ready_fc) begin
                void'(q.pop_front());
                if (m_fc < 65535) m_fc++;
            end
            if (e_vsw && ready_sw) begin
                if (half) begin
                    void'(q.pop_front());
                    if (m_sw < 65535) m_sw++;
                end
                half = !half;
            end
            if (valid_i && e_rdy) q.push_back(p);
            step();
        end
        valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_fc = 1'b0; ready_sw = 1'b0;
        node_i = '0; gen_i = '0; opr0_i = '0; opr1_i = '0; wen_i = '0;
        #1;
        test_reset();
        test_fc();
        test_sw();
        test_back_to_back();
        test_stall_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
